// File: rtl/usb_top.sv
// usb_top: a minimal USB device-side transaction engine.
//   - EP0: control endpoint. OUT is acknowledged and its data dropped; IN returns
//     a zero-length DATA1.
//   - EP1: bulk loopback through an 8-deep byte FIFO. OUT writes go to the FIFO
//     and are committed only if the whole data phase arrives clean. IN streams
//     out the committed contents.
// Optional feature macro: USB_SET_ADDRESS_EN enables SETUP / SET_ADDRESS handling.
// Without it, SETUP tokens are ignored and the device address stays 0.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   host_pkt_valid/pid/addr/ep  token strobe and fields
//   host_data_len               data-phase byte count, sampled with the token
//   host_data/_valid/crc_err    data-phase byte strobe and its CRC flag
//   host_tx_valid/pid/data/len  response beat; all fields are zero when not valid
//   dbg_addr_reg                current device address
//   dbg_ep1_fifo_level          committed EP1 FIFO occupancy (0..8)
module usb_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_pkt_valid,
  input  logic [3:0]  host_pid,
  input  logic [6:0]  host_addr,
  input  logic [3:0]  host_ep,
  input  logic [7:0]  host_data,
  input  logic        host_data_valid,
  input  logic [15:0] host_data_len,
  input  logic        host_crc_err,
  output logic        host_tx_valid,
  output logic [3:0]  host_tx_pid,
  output logic [7:0]  host_tx_data,
  output logic [15:0] host_tx_len,
  output logic [6:0]  dbg_addr_reg,
  output logic [3:0]  dbg_ep1_fifo_level
);

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;

  typedef enum logic [1:0] {IDLE, DATA, STREAM} state_t;

  state_t      state;
  logic [7:0]  fifo_mem [8];
  logic [2:0]  wr_ptr, rd_ptr, tent_ptr;
  logic [3:0]  level;
  logic [15:0] rx_remaining;
  logic [3:0]  rx_len;
  logic        rx_ep1, rx_store;
  logic [3:0]  stream_cnt;
  logic        toggle;
  logic [6:0]  addr_reg;

  logic        pid_ok, tok_ok, fits, fifo_we;
  logic [3:0]  room;

`ifdef USB_SET_ADDRESS_EN
  localparam logic [3:0] PID_SETUP = 4'hD;
  logic [6:0] pending_addr, rx_new_addr;
  logic       addr_pend, apply_addr, rx_setup, rx_setaddr, rx_len8;
  logic [1:0] rx_idx;

  // SETUP is accepted only on the control endpoint.
  assign pid_ok = (host_pid == PID_OUT) || (host_pid == PID_IN) ||
                  ((host_pid == PID_SETUP) && (host_ep[0] == 1'b0));
`else
  assign pid_ok   = (host_pid == PID_OUT) || (host_pid == PID_IN);
  assign addr_reg = 7'd0;
`endif

  // A token only counts when addressed to us, on EP0/EP1, and not during an IN stream.
  assign tok_ok = host_pkt_valid && !host_data_valid && (host_addr == addr_reg) &&
                  (host_ep[3:1] == 3'd0) && (state != STREAM) && pid_ok;

  assign room    = 4'd8 - level;
  assign fits    = (host_data_len <= {12'd0, room});
  assign fifo_we = (state == DATA) && host_data_valid && !host_crc_err && rx_ep1 && rx_store;

  assign dbg_addr_reg       = addr_reg;
  assign dbg_ep1_fifo_level = level;

  // Storage is not reset; occupancy is tracked by the pointers and level only.
  always_ff @(posedge clk) begin
    if (fifo_we) fifo_mem[tent_ptr] <= host_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= 3'd0;
      rd_ptr        <= 3'd0;
      tent_ptr      <= 3'd0;
      level         <= 4'd0;
      rx_remaining  <= 16'd0;
      rx_len        <= 4'd0;
      rx_ep1        <= 1'b0;
      rx_store      <= 1'b0;
      stream_cnt    <= 4'd0;
      toggle        <= 1'b0;
      host_tx_valid <= 1'b0;
      host_tx_pid   <= 4'd0;
      host_tx_data  <= 8'd0;
      host_tx_len   <= 16'd0;
`ifdef USB_SET_ADDRESS_EN
      addr_reg      <= 7'd0;
      pending_addr  <= 7'd0;
      rx_new_addr   <= 7'd0;
      addr_pend     <= 1'b0;
      apply_addr    <= 1'b0;
      rx_setup      <= 1'b0;
      rx_setaddr    <= 1'b0;
      rx_len8       <= 1'b0;
      rx_idx        <= 2'd0;
`endif
    end else begin
      host_tx_valid <= 1'b0;
      host_tx_pid   <= 4'd0;
      host_tx_data  <= 8'd0;
      host_tx_len   <= 16'd0;
`ifdef USB_SET_ADDRESS_EN
      // The new address takes effect once the status-stage ZLP has gone out.
      if (apply_addr) begin
        addr_reg   <= pending_addr;
        addr_pend  <= 1'b0;
        apply_addr <= 1'b0;
      end
`endif
      if (state == STREAM) begin
        host_tx_valid <= 1'b1;
        host_tx_pid   <= host_tx_pid;
        host_tx_len   <= host_tx_len;
        host_tx_data  <= fifo_mem[rd_ptr];
        rd_ptr        <= rd_ptr + 3'd1;
        level         <= level - 4'd1;
        stream_cnt    <= stream_cnt - 4'd1;
        if (stream_cnt == 4'd1) begin
          toggle <= ~toggle;
          state  <= IDLE;
        end
      end else if (tok_ok) begin
        // Any accepted token abandons an unfinished OUT phase.
        tent_ptr <= wr_ptr;
        state    <= IDLE;
        if (host_pid == PID_IN) begin
          host_tx_valid <= 1'b1;
          if (host_ep[0]) begin
            if (level != 4'd0) begin
              // First byte is loaded here; STREAM supplies the rest.
              host_tx_pid  <= toggle ? PID_DATA1 : PID_DATA0;
              host_tx_data <= fifo_mem[rd_ptr];
              host_tx_len  <= {12'd0, level};
              rd_ptr       <= rd_ptr + 3'd1;
              level        <= level - 4'd1;
              stream_cnt   <= level - 4'd1;
              if (level == 4'd1) toggle <= ~toggle;
              else               state  <= STREAM;
            end else begin
              host_tx_pid <= PID_NAK;
            end
          end else begin
            host_tx_pid <= PID_DATA1;
`ifdef USB_SET_ADDRESS_EN
            apply_addr <= addr_pend;
`endif
          end
        end else begin
          rx_ep1       <= host_ep[0];
          rx_store     <= fits;
          rx_len       <= host_data_len[3:0];
          rx_remaining <= host_data_len;
`ifdef USB_SET_ADDRESS_EN
          rx_setup   <= (host_pid == PID_SETUP);
          rx_setaddr <= 1'b0;
          rx_len8    <= (host_data_len == 16'd8);
          rx_idx     <= 2'd0;
`endif
          // A zero-length phase always fits, so it completes with ACK at once.
          if (host_data_len == 16'd0) begin
            host_tx_valid <= 1'b1;
            host_tx_pid   <= PID_ACK;
          end else begin
            state <= DATA;
          end
        end
      end else if ((state == DATA) && host_data_valid) begin
        if (host_crc_err) begin
          tent_ptr <= wr_ptr;
          state    <= IDLE;
        end else begin
          if (rx_ep1 && rx_store) tent_ptr <= tent_ptr + 3'd1;
          rx_remaining <= rx_remaining - 16'd1;
`ifdef USB_SET_ADDRESS_EN
          if (rx_idx != 2'd3) rx_idx <= rx_idx + 2'd1;
          if ((rx_idx == 2'd1) && (host_data == 8'h05)) rx_setaddr  <= 1'b1;
          if (rx_idx == 2'd2)                           rx_new_addr <= host_data[6:0];
`endif
          if (rx_remaining == 16'd1) begin
            state         <= IDLE;
            host_tx_valid <= 1'b1;
            host_tx_pid   <= (rx_ep1 && !rx_store) ? PID_NAK : PID_ACK;
            if (rx_ep1 && rx_store) begin
              wr_ptr <= tent_ptr + 3'd1;
              level  <= level + rx_len;
            end
`ifdef USB_SET_ADDRESS_EN
            if (rx_setup && rx_len8 && rx_setaddr) begin
              pending_addr <= rx_new_addr;
              addr_pend    <= 1'b1;
            end
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_top.sv
// Directed testbench for usb_top. Inputs are driven on the falling edge and
// outputs are sampled on the following falling edge, so a registered response
// to a stimulus cycle is visible as soon as applyStimulus returns.
module tb_usb_top;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;

  logic        clk, rst_n;
  logic        host_pkt_valid, host_data_valid, host_crc_err;
  logic [3:0]  host_pid, host_ep;
  logic [6:0]  host_addr;
  logic [7:0]  host_data;
  logic [15:0] host_data_len;
  logic        host_tx_valid;
  logic [3:0]  host_tx_pid;
  logic [7:0]  host_tx_data;
  logic [15:0] host_tx_len;
  logic [6:0]  dbg_addr_reg;
  logic [3:0]  dbg_ep1_fifo_level;

  int checks = 0;
  int errors = 0;

  usb_top dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .host_pkt_valid     (host_pkt_valid),
    .host_pid           (host_pid),
    .host_addr          (host_addr),
    .host_ep            (host_ep),
    .host_data          (host_data),
    .host_data_valid    (host_data_valid),
    .host_data_len      (host_data_len),
    .host_crc_err       (host_crc_err),
    .host_tx_valid      (host_tx_valid),
    .host_tx_pid        (host_tx_pid),
    .host_tx_data       (host_tx_data),
    .host_tx_len        (host_tx_len),
    .dbg_addr_reg       (dbg_addr_reg),
    .dbg_ep1_fifo_level (dbg_ep1_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns at the next falling edge with inputs idle.
  task automatic applyStimulus(input logic pv, input logic dv, input logic [3:0] pid,
                               input logic [6:0] addr, input logic [3:0] ep,
                               input logic [15:0] len, input logic [7:0] data,
                               input logic crc);
    host_pkt_valid  = pv;
    host_data_valid = dv;
    host_pid        = pid;
    host_addr       = addr;
    host_ep         = ep;
    host_data_len   = len;
    host_data       = data;
    host_crc_err    = crc;
    @(negedge clk);
    host_pkt_valid  = 1'b0;
    host_data_valid = 1'b0;
    host_pid        = 4'd0;
    host_addr       = 7'd0;
    host_ep         = 4'd0;
    host_data_len   = 16'd0;
    host_data       = 8'd0;
    host_crc_err    = 1'b0;
  endtask

  task automatic sendToken(input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] ep, input logic [15:0] len);
    applyStimulus(1'b1, 1'b0, pid, addr, ep, len, 8'd0, 1'b0);
  endtask

  task automatic sendByte(input logic [7:0] data, input logic crc);
    applyStimulus(1'b0, 1'b1, 4'd0, 7'd0, 4'd0, 16'd0, data, crc);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, {3'b0, host_tx_valid, host_tx_pid, host_tx_data, host_tx_len}, 32'd0);
  endtask

  task automatic checkBeat(input string tag, input logic [3:0] pid,
                           input logic [7:0] data, input logic [15:0] len);
    checkOutput(tag, {3'b0, host_tx_valid, host_tx_pid, host_tx_data, host_tx_len},
                {3'b0, 1'b1, pid, data, len});
  endtask

  task automatic checkLevel(input string tag, input logic [3:0] expected);
    checkOutput(tag, {28'd0, dbg_ep1_fifo_level}, {28'd0, expected});
  endtask

  initial begin
    rst_n = 1'b0;
    host_pkt_valid = 1'b0; host_data_valid = 1'b0; host_crc_err = 1'b0;
    host_pid = 4'd0; host_addr = 7'd0; host_ep = 4'd0;
    host_data = 8'd0; host_data_len = 16'd0;
    repeat (2) @(negedge clk);
    checkIdle("reset_outputs");
    checkLevel("reset_level", 4'd0);
    checkOutput("reset_addr", {25'd0, dbg_addr_reg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty IN on EP1 gets a single NAK.
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    checkBeat("empty_in_nak", PID_NAK, 8'd0, 16'd0);
    @(negedge clk);
    checkIdle("empty_in_done");

    // Loopback: 8 bytes in, ACK, then 8 bytes out as DATA0.
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd8);
    checkIdle("lb_token");
    for (int i = 0; i < 8; i++) begin
      sendByte(8'hA1 + 8'(i), 1'b0);
      if (i < 7) begin
        checkIdle($sformatf("lb_byte%0d", i));
        @(negedge clk);
      end
    end
    checkBeat("lb_ack", PID_ACK, 8'd0, 16'd0);
    checkLevel("lb_level_full", 4'd8);
    @(negedge clk);
    checkIdle("lb_ack_single");
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      checkBeat($sformatf("lb_in_beat%0d", k), PID_DATA0, 8'hA1 + 8'(k), 16'd8);
      checkLevel($sformatf("lb_in_level%0d", k), 4'(7 - k));
    end
    @(negedge clk);
    checkIdle("lb_in_done");

    // CRC error on byte 2 drops the whole phase silently.
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd4);
    sendByte(8'h11, 1'b0); checkIdle("crc_b1");
    sendByte(8'h22, 1'b1); checkIdle("crc_b2");
    sendByte(8'h33, 1'b0); checkIdle("crc_b3");
    sendByte(8'h44, 1'b0); checkIdle("crc_b4");
    @(negedge clk);
    checkIdle("crc_no_resp");
    checkLevel("crc_level", 4'd0);
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    checkBeat("crc_in_nak", PID_NAK, 8'd0, 16'd0);
    @(negedge clk);

    // Reset asserted mid-stream: everything clears at once and stays quiet.
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd3);
    sendByte(8'h71, 1'b0); sendByte(8'h72, 1'b0); sendByte(8'h73, 1'b0);
    checkBeat("rst_pre_ack", PID_ACK, 8'd0, 16'd0);
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    checkBeat("rst_pre_beat0", PID_DATA1, 8'h71, 16'd3);
    rst_n = 1'b0;
    #1;
    checkIdle("rst_async_outputs");
    checkLevel("rst_async_level", 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("rst_after_release");

    // Overflow: second OUT does not fit and is NAKed; toggle alternates across INs.
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd6);
    for (int i = 0; i < 6; i++) sendByte(8'h10 + 8'(i), 1'b0);
    checkBeat("ovf_ack", PID_ACK, 8'd0, 16'd0);
    checkLevel("ovf_level6", 4'd6);
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd4);
    for (int i = 0; i < 4; i++) sendByte(8'h20 + 8'(i), 1'b0);
    checkBeat("ovf_nak", PID_NAK, 8'd0, 16'd0);
    checkLevel("ovf_level_kept", 4'd6);
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checkBeat($sformatf("ovf_in_beat%0d", k), PID_DATA0, 8'h10 + 8'(k), 16'd6);
    end
    @(negedge clk);
    checkIdle("ovf_in_done");
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd2);
    sendByte(8'h30, 1'b0); sendByte(8'h31, 1'b0);
    checkBeat("wrap_ack", PID_ACK, 8'd0, 16'd0);
    checkLevel("wrap_level", 4'd2);
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    checkBeat("wrap_beat0", PID_DATA1, 8'h30, 16'd2);
    @(negedge clk);
    checkBeat("wrap_beat1", PID_DATA1, 8'h31, 16'd2);
    @(negedge clk);
    checkIdle("wrap_done");

    // Token mid-phase aborts the OUT and is itself processed.
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd4);
    sendByte(8'h40, 1'b0); sendByte(8'h41, 1'b0);
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    checkBeat("abort_in_nak", PID_NAK, 8'd0, 16'd0);
    checkLevel("abort_level", 4'd0);
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd1);
    sendByte(8'h55, 1'b0);
    checkBeat("abort_refill_ack", PID_ACK, 8'd0, 16'd0);
    sendToken(PID_IN, 7'd0, 4'd1, 16'd0);
    checkBeat("abort_refill_in", PID_DATA0, 8'h55, 16'd1);
    @(negedge clk);
    checkIdle("abort_refill_done");

    // Zero-length OUT completes immediately.
    sendToken(PID_OUT, 7'd0, 4'd1, 16'd0);
    checkBeat("zlp_out_ack", PID_ACK, 8'd0, 16'd0);
    checkLevel("zlp_out_level", 4'd0);
    @(negedge clk);

    // Address / endpoint filtering.
    sendToken(PID_IN, 7'd5, 4'd1, 16'd0);
    checkIdle("filt_in_addr5");
    sendToken(PID_OUT, 7'd5, 4'd1, 16'd1);
    sendByte(8'h66, 1'b0);
    checkIdle("filt_out_addr5");
    checkLevel("filt_level", 4'd0);
    sendToken(PID_IN, 7'd0, 4'd2, 16'd0);
    checkIdle("filt_ep2");

    // EP0 control traffic.
    sendToken(PID_OUT, 7'd0, 4'd0, 16'd2);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    checkBeat("ep0_out_ack", PID_ACK, 8'd0, 16'd0);
    checkLevel("ep0_out_level", 4'd0);
    sendToken(PID_IN, 7'd0, 4'd0, 16'd0);
    checkBeat("ep0_in_zlp", PID_DATA1, 8'd0, 16'd0);
    @(negedge clk);
    checkIdle("ep0_in_done");

    // SET_ADDRESS request: 00 05 05 00 00 00 00 00.
    sendToken(PID_SETUP, 7'd0, 4'd0, 16'd8);
    sendByte(8'h00, 1'b0); sendByte(8'h05, 1'b0); sendByte(8'h05, 1'b0);
    for (int i = 0; i < 5; i++) sendByte(8'h00, 1'b0);
`ifdef USB_SET_ADDRESS_EN
    checkBeat("setaddr_ack", PID_ACK, 8'd0, 16'd0);
    sendToken(PID_IN, 7'd0, 4'd0, 16'd0);
    checkBeat("setaddr_status", PID_DATA1, 8'd0, 16'd0);
    checkOutput("setaddr_old", {25'd0, dbg_addr_reg}, 32'd0);
    @(negedge clk);
    checkOutput("setaddr_new", {25'd0, dbg_addr_reg}, 32'd5);
    sendToken(PID_IN, 7'd0, 4'd0, 16'd0);
    checkIdle("setaddr_old_ignored");
    sendToken(PID_IN, 7'd5, 4'd0, 16'd0);
    checkBeat("setaddr_new_in", PID_DATA1, 8'd0, 16'd0);
    @(negedge clk);
`else
    checkIdle("setup_ignored");
    @(negedge clk);
    checkIdle("setup_no_resp");
    checkOutput("setup_addr_zero", {25'd0, dbg_addr_reg}, 32'd0);
    sendToken(PID_IN, 7'd0, 4'd0, 16'd0);
    checkBeat("setup_after_in", PID_DATA1, 8'd0, 16'd0);
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
